// File: rtl/ticket_pkg.sv
// ticket_pkg -- shared types and constants for the multi-ticket vendor.
// Holds the controller state enum, the accepted coin denominations and
// the default two-entry price table (type 0 = 15, type 1 = 20).
package ticket_pkg;

  // Controller phases: IDLE (no credit), ACCUM (credit held),
  // DISPENSE (ticket pulse out), CHANGE (refund pulse out).
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  // Coin denominations, in credit units.
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_50 = 50;

  // Default price table geometry and contents.
  localparam int DEFAULT_NUM_TICKETS = 2;
  localparam int DEFAULT_PRICE_W     = 8;
  localparam logic [DEFAULT_NUM_TICKETS*DEFAULT_PRICE_W-1:0] DEFAULT_PRICES = {8'd20, 8'd15};

endpackage : ticket_pkg

// File: rtl/multi_ticket_vendor_if.sv
// multi_ticket_vendor_if -- coin/select/cancel inputs and the dispense,
// refund and status outputs of the vendor, bundled as one interface.
// master: the customer side (drives pulses, observes results).
// slave:  the vendor controller.
interface multi_ticket_vendor_if #(
  parameter int NUM_TICKETS = 2,
  parameter int CREDIT_W    = 10
);

  logic                   money_5;
  logic                   money_10;
  logic                   money_50;
  logic                   cancel;
  logic [NUM_TICKETS-1:0] ticket_sel;

  logic [CREDIT_W-1:0]    credit;
  logic [NUM_TICKETS-1:0] drop_ticket;
  logic [CREDIT_W-1:0]    drop_money;
  logic                   coin_reject;
  logic                   insufficient;

  modport master (
    output money_5, money_10, money_50, cancel, ticket_sel,
    input  credit, drop_ticket, drop_money, coin_reject, insufficient
  );

  modport slave (
    input  money_5, money_10, money_50, cancel, ticket_sel,
    output credit, drop_ticket, drop_money, coin_reject, insufficient
  );

endinterface : multi_ticket_vendor_if

// File: rtl/ticket_idle_timer.sv
// ticket_idle_timer -- restartable down-counter that flags TIMEOUT_CYCLES
// consecutive cycles of 'run' without 'restart'. The timeout flag is
// combinational so the owner can act on the same edge that ends the
// idle window. Only compiled when TICKET_TIMEOUT_EN is defined.
`ifdef TICKET_TIMEOUT_EN
module ticket_idle_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // remaining == 0 means "disarmed": the first idle cycle arms the counter
  // with TIMEOUT_CYCLES-1, and the idle cycle that sees 1 is the last one.
  logic [CNT_W-1:0] remaining;
  logic             counting;

  assign counting = run && !restart;
  assign timeout  = counting && ((remaining == CNT_W'(1)) || (TIMEOUT_CYCLES == 1));

  // Count idle cycles down; any pulse, leaving ACCUM or expiry disarms.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining <= '0;
    end else if (!counting || timeout) begin
      remaining <= '0;
    end else if (remaining == '0) begin
      remaining <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else begin
      remaining <= remaining - CNT_W'(1);
    end
  end

endmodule : ticket_idle_timer
`endif

// File: rtl/multi_ticket_vendor.sv
// multi_ticket_vendor -- multi-type ticket vending controller.
// Accepts 5/10/50 coins up to MAX_CREDIT, sells the lowest-index selected
// ticket when credit covers its price, then pays out the remainder.
// Per-cycle priority is cancel > ticket_sel > coin; a coin that is not
// credited for any reason raises coin_reject on the following cycle.
// A cancel pulse always claims its cycle, even in IDLE where it has no
// effect of its own.
// Optional feature: define TICKET_TIMEOUT_EN to refund the credit after
// TIMEOUT_CYCLES consecutive pulse-free cycles in ACCUM.
module multi_ticket_vendor
  import ticket_pkg::*;
#(
  parameter int                             NUM_TICKETS    = DEFAULT_NUM_TICKETS,
  parameter int                             PRICE_W        = DEFAULT_PRICE_W,
  parameter logic [NUM_TICKETS*PRICE_W-1:0] PRICES         = DEFAULT_PRICES,
  parameter int                             CREDIT_W       = 10,
  parameter int                             MAX_CREDIT     = 100,
  parameter int                             TIMEOUT_CYCLES = 256
) (
  input logic                  clk,
  input logic                  reset,
  multi_ticket_vendor_if.slave bus
);

  // Registered state and outputs.
  state_t                 state_q;
  logic [CREDIT_W-1:0]    credit_q;
  logic [NUM_TICKETS-1:0] drop_ticket_q;
  logic [CREDIT_W-1:0]    drop_money_q;
  logic                   coin_reject_q;
  logic                   insufficient_q;

  // Decoded view of this cycle's input pulses.
  logic                   coin_any;
  logic                   coin_multi;
  logic [CREDIT_W-1:0]    coin_val;
  logic [CREDIT_W:0]      coin_sum;
  logic                   coin_fits;
  logic                   sel_any;
  logic [NUM_TICKETS-1:0] sel_onehot;
  logic [CREDIT_W-1:0]    sel_cost;
  logic                   sel_affordable;
  logic                   any_pulse;
  logic                   timeout;

  // Decode coins (largest wins) and selections (lowest index wins).
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves one unassigned, which would otherwise infer a latch.
    coin_val = '0;
    sel_cost = '0;

    coin_any   = bus.money_5 | bus.money_10 | bus.money_50;
    coin_multi = (bus.money_5  & bus.money_10) |
                 (bus.money_5  & bus.money_50) |
                 (bus.money_10 & bus.money_50);

    if (bus.money_50) begin
      coin_val = CREDIT_W'(COIN_50);
    end else if (bus.money_10) begin
      coin_val = CREDIT_W'(COIN_10);
    end else if (bus.money_5) begin
      coin_val = CREDIT_W'(COIN_5);
    end

    // Widened by one bit so an over-ceiling sum cannot wrap into range.
    coin_sum  = (CREDIT_W+1)'(credit_q) + (CREDIT_W+1)'(coin_val);
    coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

    // x & -x isolates the lowest set bit: the winning ticket type.
    sel_any    = |bus.ticket_sel;
    sel_onehot = bus.ticket_sel & (~bus.ticket_sel + NUM_TICKETS'(1));
    for (int i = 0; i < NUM_TICKETS; i++) begin
      if (sel_onehot[i]) begin
        sel_cost = CREDIT_W'(PRICES[i*PRICE_W +: PRICE_W]);
      end
    end
    sel_affordable = credit_q >= sel_cost;

    any_pulse = coin_any | bus.cancel | sel_any;
  end

`ifdef TICKET_TIMEOUT_EN
  ticket_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == ST_ACCUM),
    .restart (any_pulse),
    .timeout (timeout)
  );
`else
  // Without the timer, ACCUM holds its credit indefinitely.
  assign timeout = 1'b0;
`endif

  // Controller FSM with registered outputs; every output pulse defaults low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Pending credit is discarded without any refund pulse.
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      drop_ticket_q  <= '0;
      drop_money_q   <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge values of the others, independent of statement order.
      drop_ticket_q  <= '0;
      drop_money_q   <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (bus.cancel) begin
            // Cancel claims the cycle; selects and coins are dropped.
            coin_reject_q <= coin_any;
            if (state_q == ST_ACCUM) begin
              drop_money_q <= credit_q;
              credit_q     <= '0;
              state_q      <= ST_CHANGE;
            end
          end else if (sel_any) begin
            coin_reject_q <= coin_any;
            if (sel_affordable) begin
              drop_ticket_q <= sel_onehot;
              credit_q      <= credit_q - sel_cost;
              state_q       <= ST_DISPENSE;
            end else begin
              insufficient_q <= 1'b1;
            end
          end else if (timeout) begin
            // Only reachable on a pulse-free cycle, so no coin to reject.
            drop_money_q <= credit_q;
            credit_q     <= '0;
            state_q      <= ST_CHANGE;
          end else if (coin_any) begin
            if (coin_fits) begin
              credit_q      <= coin_sum[CREDIT_W-1:0];
              coin_reject_q <= coin_multi;
              state_q       <= ST_ACCUM;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end

        ST_DISPENSE: begin
          // Pay out whatever the sale left; zero credit gives no pulse.
          coin_reject_q <= coin_any;
          drop_money_q  <= credit_q;
          credit_q      <= '0;
          state_q       <= ST_CHANGE;
        end

        ST_CHANGE: begin
          coin_reject_q <= coin_any;
          state_q       <= ST_IDLE;
        end

        default: begin
          state_q  <= ST_IDLE;
          credit_q <= '0;
        end
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.drop_ticket  = drop_ticket_q;
  assign bus.drop_money   = drop_money_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.insufficient = insufficient_q;

endmodule : multi_ticket_vendor

// File: tb/tb_multi_ticket_vendor.sv
// tb_multi_ticket_vendor -- directed scenarios plus a randomized run
// against a transaction-level model of the vendor (credit balance, a
// count of cycles during which inputs are ignored, a pending payout).
// Build with TICKET_TIMEOUT_EN defined to exercise the idle refund.
module tb_multi_ticket_vendor;

  localparam int NT   = 2;
  localparam int CW   = 10;
  localparam int MAXC = 100;
  localparam int TO   = 8;

  logic clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  int price_tab [NT] = '{15, 20};

  // Reference model state.
  int m_credit;
  int m_busy;
  int m_idle;
  bit m_refund_due;

  multi_ticket_vendor_if #(.NUM_TICKETS(NT), .CREDIT_W(CW)) bus ();

  multi_ticket_vendor #(
    .NUM_TICKETS    (NT),
    .PRICE_W        (8),
    .PRICES         ({8'd20, 8'd15}),
    .CREDIT_W       (CW),
    .MAX_CREDIT     (MAXC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of input pulses, then sample 1 time unit after the edge.
  task automatic cycle(input bit m5, input bit m10, input bit m50,
                       input bit c, input logic [NT-1:0] sel);
    bus.money_5    = m5;
    bus.money_10   = m10;
    bus.money_50   = m50;
    bus.cancel     = c;
    bus.ticket_sel = sel;
    @(posedge clk);
    #1;
    bus.money_5    = 1'b0;
    bus.money_10   = 1'b0;
    bus.money_50   = 1'b0;
    bus.cancel     = 1'b0;
    bus.ticket_sel = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_credit = 0; m_busy = 0; m_idle = 0; m_refund_due = 1'b0;
  endtask

  // Behavioural model: expected outputs after one clock edge.
  task automatic model_step(input bit m5, input bit m10, input bit m50,
                            input bit c, input logic [NT-1:0] sel,
                            output int e_credit, output int e_ticket,
                            output int e_money, output bit e_reject,
                            output bit e_insuff);
    int coins;
    int coin_v;
    int idx;
    coins  = int'(m5) + int'(m10) + int'(m50);
    coin_v = m50 ? 50 : (m10 ? 10 : (m5 ? 5 : 0));
    e_ticket = 0; e_money = 0; e_reject = 1'b0; e_insuff = 1'b0;
    if (m_busy > 0) begin
      e_reject = coins > 0;
      if (m_refund_due) begin
        e_money = m_credit; m_credit = 0; m_refund_due = 1'b0;
      end
      m_busy--; m_idle = 0;
    end else if (c) begin
      e_reject = coins > 0;
      if (m_credit > 0) begin
        e_money = m_credit; m_credit = 0; m_busy = 1;
      end
      m_idle = 0;
    end else if (sel != '0) begin
      e_reject = coins > 0;
      idx = 0;
      while (!sel[idx]) idx++;
      if (m_credit >= price_tab[idx]) begin
        e_ticket = 1 << idx;
        m_credit -= price_tab[idx];
        m_busy = 2; m_refund_due = 1'b1;
      end else begin
        e_insuff = 1'b1;
      end
      m_idle = 0;
    end else if (coins > 0) begin
      if (m_credit + coin_v <= MAXC) begin
        m_credit += coin_v;
        e_reject = coins > 1;
      end else begin
        e_reject = 1'b1;
      end
      m_idle = 0;
    end else if (m_credit > 0) begin
`ifdef TICKET_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin
        e_money = m_credit; m_credit = 0; m_busy = 1; m_idle = 0;
      end
`endif
    end
    e_credit = m_credit;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.credit !== '0) begin errors++; $display("FAIL reset_credit: got %0d want 0", bus.credit); end
    checks++; if (bus.drop_ticket !== '0) begin errors++; $display("FAIL reset_ticket: got %b want 00", bus.drop_ticket); end
    checks++; if (bus.drop_money !== '0) begin errors++; $display("FAIL reset_money: got %0d want 0", bus.drop_money); end
    checks++; if ({bus.coin_reject, bus.insufficient} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.coin_reject, bus.insufficient}); end
    apply_reset();
  endtask

  // Coins 10,5 then type 0 (price 15): exact payment, no change.
  task automatic test_exact_sale();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.credit !== CW'(15)) begin errors++; $display("FAIL exact_credit: got %0d want 15", bus.credit); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checks++; if (bus.drop_ticket !== 2'b01) begin errors++; $display("FAIL exact_ticket: got %b want 01", bus.drop_ticket); end
    checks++; if (bus.credit !== '0) begin errors++; $display("FAIL exact_credit_after: got %0d want 0", bus.credit); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.drop_ticket !== 2'b00) begin errors++; $display("FAIL exact_ticket_one_cycle: got %b want 00", bus.drop_ticket); end
    checks++; if (bus.drop_money !== '0) begin errors++; $display("FAIL exact_no_change: got %0d want 0", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Coins 50,10 then type 1 (price 20): change of 40 one cycle later.
  task automatic test_sale_change();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checks++; if (bus.drop_ticket !== 2'b10) begin errors++; $display("FAIL change_ticket: got %b want 10", bus.drop_ticket); end
    checks++; if (bus.drop_money !== '0) begin errors++; $display("FAIL change_early_money: got %0d want 0", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.drop_money !== CW'(40)) begin errors++; $display("FAIL change_money: got %0d want 40", bus.drop_money); end
    checks++; if (bus.credit !== '0) begin errors++; $display("FAIL change_credit: got %0d want 0", bus.credit); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.drop_money !== '0) begin errors++; $display("FAIL change_money_one_cycle: got %0d want 0", bus.drop_money); end
  endtask

  // Credit ceiling: 95+10 rejected, 95+5 reaches exactly 100 elsewhere.
  task automatic test_ceiling();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if (bus.coin_reject !== 1'b1) begin errors++; $display("FAIL ceil_reject: got %b want 1", bus.coin_reject); end
    checks++; if (bus.credit !== CW'(95)) begin errors++; $display("FAIL ceil_credit: got %0d want 95", bus.credit); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++; if (bus.drop_money !== CW'(95)) begin errors++; $display("FAIL ceil_refund: got %0d want 95", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++; if (bus.credit !== CW'(100)) begin errors++; $display("FAIL ceil_full: got %0d want 100", bus.credit); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++; if ({bus.coin_reject, bus.credit} !== {1'b1, CW'(100)}) begin errors++; $display("FAIL ceil_full_reject: got %b/%0d want 1/100", bus.coin_reject, bus.credit); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++; if (bus.drop_money !== CW'(100)) begin errors++; $display("FAIL ceil_full_refund: got %0d want 100", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Insufficient credit, then cancel beating a same-cycle coin.
  task automatic test_insufficient();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
    checks++; if (bus.insufficient !== 1'b1) begin errors++; $display("FAIL insuff_pulse: got %b want 1", bus.insufficient); end
    checks++; if ({bus.credit, bus.drop_ticket} !== {CW'(10), 2'b00}) begin errors++; $display("FAIL insuff_hold: got %0d/%b want 10/00", bus.credit, bus.drop_ticket); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
    checks++; if (bus.insufficient !== 1'b0) begin errors++; $display("FAIL insuff_one_cycle: got %b want 0", bus.insufficient); end
    checks++; if (bus.drop_money !== CW'(10)) begin errors++; $display("FAIL cancel_refund: got %0d want 10", bus.drop_money); end
    checks++; if (bus.coin_reject !== 1'b1) begin errors++; $display("FAIL cancel_coin_reject: got %b want 1", bus.coin_reject); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Multi-coin, select+coin, and coins during DISPENSE/CHANGE.
  task automatic test_priority();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checks++; if ({bus.credit, bus.coin_reject} !== {CW'(50), 1'b1}) begin errors++; $display("FAIL multi_coin: got %0d/%b want 50/1", bus.credit, bus.coin_reject); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    checks++; if ({bus.drop_ticket, bus.credit, bus.coin_reject} !== {2'b01, CW'(35), 1'b1}) begin errors++; $display("FAIL sel_beats_coin: got %b/%0d/%b want 01/35/1", bus.drop_ticket, bus.credit, bus.coin_reject); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checks++; if ({bus.drop_money, bus.coin_reject} !== {CW'(35), 1'b1}) begin errors++; $display("FAIL dispense_coin: got %0d/%b want 35/1", bus.drop_money, bus.coin_reject); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if ({bus.credit, bus.coin_reject} !== {CW'(0), 1'b1}) begin errors++; $display("FAIL change_coin: got %0d/%b want 0/1", bus.credit, bus.coin_reject); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checks++; if ({bus.credit, bus.coin_reject} !== {CW'(10), 1'b0}) begin errors++; $display("FAIL idle_again: got %0d/%b want 10/0", bus.credit, bus.coin_reject); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Reset asserted during DISPENSE with 5 left over: nothing is refunded.
  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checks++; if (bus.drop_ticket !== 2'b01) begin errors++; $display("FAIL mid_ticket: got %b want 01", bus.drop_ticket); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({bus.drop_ticket, bus.credit, bus.drop_money} !== '0) begin errors++; $display("FAIL mid_async_clear: got %b/%0d/%0d want 00/0/0", bus.drop_ticket, bus.credit, bus.drop_money); end
    @(posedge clk);
    #1 reset = 1'b1;
    m_credit = 0; m_busy = 0; m_idle = 0; m_refund_due = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      checks++; if ({bus.drop_money, bus.credit} !== '0) begin errors++; $display("FAIL mid_no_refund: got %0d/%0d want 0/0", bus.drop_money, bus.credit); end
    end
  endtask

  // Idle behaviour in ACCUM with credit 5.
  task automatic test_timeout();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
`ifdef TICKET_TIMEOUT_EN
    repeat (TO - 1) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.drop_money !== '0) begin errors++; $display("FAIL timeout_early: got %0d want 0", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checks++; if (bus.drop_money !== CW'(5)) begin errors++; $display("FAIL timeout_refund: got %0d want 5", bus.drop_money); end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
`else
    for (int k = 0; k < 3 * TO; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      checks++; if ({bus.drop_money, bus.credit} !== {CW'(0), CW'(5)}) begin errors++; $display("FAIL hold_credit: got %0d/%0d want 0/5", bus.drop_money, bus.credit); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
`endif
  endtask

  // Random pulses checked every cycle against the model.
  task automatic test_random();
    bit m5, m10, m50, c;
    logic [NT-1:0] sel;
    int e_credit, e_ticket, e_money;
    bit e_reject, e_insuff;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      m5  = ($urandom_range(0, 3) == 0);
      m10 = ($urandom_range(0, 3) == 0);
      m50 = ($urandom_range(0, 7) == 0);
      c   = ($urandom_range(0, 24) == 0);
      sel = NT'($urandom_range(0, 15) < 2 ? $urandom_range(1, 3) : 0);
      if ($urandom_range(0, 9) < 3) begin
        m5 = 1'b0; m10 = 1'b0; m50 = 1'b0; c = 1'b0; sel = '0;
      end
      model_step(m5, m10, m50, c, sel, e_credit, e_ticket, e_money, e_reject, e_insuff);
      cycle(m5, m10, m50, c, sel);
      checks++; if (bus.credit !== CW'(e_credit)) begin errors++; $display("FAIL rnd_credit n=%0d: got %0d want %0d", n, bus.credit, e_credit); end
      checks++; if (bus.drop_ticket !== NT'(e_ticket)) begin errors++; $display("FAIL rnd_ticket n=%0d: got %b want %b", n, bus.drop_ticket, NT'(e_ticket)); end
      checks++; if (bus.drop_money !== CW'(e_money)) begin errors++; $display("FAIL rnd_money n=%0d: got %0d want %0d", n, bus.drop_money, e_money); end
      checks++; if (bus.coin_reject !== e_reject) begin errors++; $display("FAIL rnd_reject n=%0d: got %b want %b", n, bus.coin_reject, e_reject); end
      checks++; if (bus.insufficient !== e_insuff) begin errors++; $display("FAIL rnd_insuff n=%0d: got %b want %b", n, bus.insufficient, e_insuff); end
    end
  endtask

  initial begin
    bus.money_5 = 1'b0; bus.money_10 = 1'b0; bus.money_50 = 1'b0;
    bus.cancel = 1'b0; bus.ticket_sel = '0;
    test_reset();
    test_exact_sale();
    test_sale_change();
    test_ceiling();
    test_insufficient();
    test_priority();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multi_ticket_vendor

// File: doc/multi_ticket_vendor.md
MULTI_TICKET_VENDOR -- requirements
Module: multi_ticket_vendor

Interface
REQ-001 Parameter NUM_TICKETS, default 2, number of ticket types.
REQ-002 Parameter PRICE_W, default 8, width of one price field.
REQ-003 Parameter PRICES, default {8'd20, 8'd15}, packed NUM_TICKETS*PRICE_W price table; type i occupies bits [i*PRICE_W +: PRICE_W], so type 0=15 and type 1=20.
REQ-004 Parameter CREDIT_W, default 10, width of credit and change values.
REQ-005 Parameter MAX_CREDIT, default 100, credit ceiling.
REQ-006 Parameter TIMEOUT_CYCLES, default 256, idle limit; used only under TICKET_TIMEOUT_EN.
REQ-007 clk  input  1  single clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 money_5 / money_10 / money_50  input  1 each  one-cycle coin pulses, already debounced and one-pulsed.
REQ-010 cancel  input  1  one-cycle cancel pulse.
REQ-011 ticket_sel  input  NUM_TICKETS  one-cycle select pulses, one bit per type.
REQ-012 credit  output  CREDIT_W  current accumulated credit, registered.
REQ-013 drop_ticket  output  NUM_TICKETS  one-cycle dispense pulse, at most one bit high.
REQ-014 drop_money  output  CREDIT_W  change value, non-zero for exactly one cycle per refund.
REQ-015 coin_reject  output  1  one-cycle pulse when an inserted coin is not credited.
REQ-016 insufficient  output  1  one-cycle pulse when a selection exceeds credit.

Function
REQ-017 States: IDLE, ACCUM, DISPENSE, CHANGE; IDLE when credit==0, ACCUM when credit>0.
REQ-018 Per-cycle priority: cancel > ticket_sel > coin; lower-priority events in the same cycle are dropped, and a dropped coin raises coin_reject next cycle.
REQ-019 Several coin pulses in one cycle: only the largest denomination is considered; the others raise coin_reject.
REQ-020 Coin in IDLE/ACCUM: credit+value if result <= MAX_CREDIT, else credit unchanged and coin_reject pulses; the update is visible on credit the next cycle.
REQ-021 Several ticket_sel bits high: the lowest index wins and the others are ignored.
REQ-022 Select i with credit >= PRICES[i]: go to DISPENSE; drop_ticket[i]=1 for one cycle; credit -= PRICES[i].
REQ-023 Select i with credit < PRICES[i]: insufficient pulses one cycle; state and credit are unchanged.
REQ-024 After DISPENSE, go to CHANGE: drop_money=credit for one cycle (only if credit>0); credit cleared; return to IDLE.
REQ-025 Latency: select to drop_ticket is 1 cycle, and drop_ticket to drop_money is 1 cycle.
REQ-026 Cancel in ACCUM: go to CHANGE, refund full credit; cancel in IDLE is ignored.
REQ-027 Every input pulse arriving while in DISPENSE or CHANGE is ignored; coins so dropped raise coin_reject.
REQ-028 credit arithmetic is unsigned CREDIT_W bits; credit never wraps and never exceeds MAX_CREDIT.

Reset
REQ-029 reset low: state=IDLE, credit=0, drop_ticket=0, drop_money=0, coin_reject=0, insufficient=0, idle timer=0; asserts immediately, mid-transaction included; any pending credit is discarded without refund.

Configuration
REQ-030 Macro TICKET_TIMEOUT_EN defined: in ACCUM, TIMEOUT_CYCLES consecutive cycles with no input pulse force CHANGE with a full refund; any pulse restarts the count.
REQ-031 TICKET_TIMEOUT_EN undefined: no timer logic; ACCUM holds indefinitely.

Structure
REQ-032 Package ticket_pkg holds: the state enum, coin value constants (5/10/50), and the default price table.
REQ-033 One sub-module, ticket_idle_timer (restartable down-counter, timeout pulse), is instantiated only under TICKET_TIMEOUT_EN.

Verification
REQ-034 Coins 10,5 then ticket_sel=01 -> credit 15, drop_ticket=01 one cycle, drop_money 0, IDLE.
REQ-035 Coins 50,10 then ticket_sel=10 -> drop_ticket=10, next cycle drop_money=40, credit=0.
REQ-036 Credit 95 then money_10 -> coin_reject pulse, credit stays 95; cancel -> drop_money=95.
REQ-037 Credit 10, ticket_sel=11 -> insufficient pulse, credit 10; same cycle cancel+money_5 -> drop_money=10, coin_reject pulse.
REQ-038 Credit 20, reset low during DISPENSE -> all outputs 0 immediately, state IDLE, no drop_money.
REQ-039 TICKET_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, credit 5, then idle -> drop_money=5 after 8 idle cycles; undefined -> credit remains 5.
